// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive controller.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        COMMIT
    } rx_ctrl_state_t;

    localparam int DIV_W             = 16;
    localparam int CAPTURE_EDGE_DEF  = 70;
    localparam int FRAME_EDGES_DEF   = 72;
    localparam int TIMEOUT_EDGES_DEF = 320;

    function automatic logic [DIV_W-1:0] div_limit(input logic [DIV_W-1:0] cfg);
        return (cfg == '0) ? DIV_W'(1) : cfg;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side and host-side signals of the UART receive controller.
interface uart_rx_ctrl_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                       rx_en;
    logic [uart_pkg::DIV_W-1:0] cfg_div;
    logic                       bclkx8;
    logic                       rx_status;
    logic [7:0]                 rhr;
    logic                       rd_en;
    logic [7:0]                 rd_data;
    logic                       rd_valid;
    logic [CW-1:0]              fifo_count;
    logic                       overrun;
    logic                       ovr_clr;
    logic                       rx_timeout;

    modport slave (
        input  rx_en, cfg_div, rx_status, rhr, rd_en, ovr_clr,
        output bclkx8, rd_data, rd_valid, fifo_count, overrun, rx_timeout
    );

    modport master (
        output rx_en, cfg_div, rx_status, rhr, rd_en, ovr_clr,
        input  bclkx8, rd_data, rd_valid, fifo_count, overrun, rx_timeout
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through sync FIFO; head is registered and tracks pops.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  rdata_q, head_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign rd_ptr_d = rd_ptr_q + AW'(do_pop);
    assign count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    // The new head may be the very byte being written this cycle.
    assign head_d   = (do_push && wr_ptr_q == rd_ptr_d) ? wdata_i : mem[rd_ptr_d];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (count_d != '0) begin
                rdata_q <= head_d;
            end
        end
    end

    assign rdata_o = rdata_q;
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: bclkx8 generation, frame tracking, byte FIFO.
// Optional idle timeout flag is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int CAPTURE_EDGE  = CAPTURE_EDGE_DEF,
    parameter int FRAME_EDGES   = FRAME_EDGES_DEF
`ifdef UART_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_EDGES = TIMEOUT_EDGES_DEF
`endif
) (
    input logic           sys_clk,
    input logic           rst_n,
    uart_rx_ctrl_if.slave bus
);
    localparam logic [6:0] CAP_E = 7'(CAPTURE_EDGE);
    localparam logic [6:0] FRM_E = 7'(FRAME_EDGES);

    logic [DIV_W-1:0] div_cnt_q, div_lim_q;
    logic             bclk_q, rise_q, term;

    assign term = (div_cnt_q >= div_lim_q - DIV_W'(1));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            div_lim_q <= DIV_W'(1);
            bclk_q    <= 1'b0;
            rise_q    <= 1'b0;
        end else if (!bus.rx_en) begin
            div_cnt_q <= '0;
            div_lim_q <= div_limit(bus.cfg_div);
            bclk_q    <= 1'b0;
            rise_q    <= 1'b0;
        end else if (term) begin
            div_cnt_q <= '0;
            div_lim_q <= div_limit(bus.cfg_div);
            bclk_q    <= ~bclk_q;
            rise_q    <= ~bclk_q;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
            rise_q    <= 1'b0;
        end
    end

    rx_ctrl_state_t state_q;
    logic [6:0]     edge_q, edge_d;

    assign edge_d = edge_q + 7'd1;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            edge_q  <= '0;
        end else if (!bus.rx_en) begin
            state_q <= IDLE;
            edge_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    edge_q <= '0;
                    if (bus.rx_status) state_q <= FRAME;
                end
                FRAME: begin
                    if (!bus.rx_status) begin
                        state_q <= IDLE;
                        edge_q  <= '0;
                    end else if (rise_q) begin
                        if (edge_d == FRM_E) begin
                            edge_q <= '0;
                        end else begin
                            edge_q <= edge_d;
                            if (edge_d == CAP_E) state_q <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    state_q <= FRAME;
                    if (rise_q) edge_q <= edge_d;
                end
                default: begin
                    state_q <= IDLE;
                    edge_q  <= '0;
                end
            endcase
        end
    end

    // RHR has settled by the cycle spent in COMMIT.
    logic push, full, empty, overrun_q;

    assign push = (state_q == COMMIT);

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (bus.rhr),
        .pop_i   (bus.rd_en),
        .rdata_o (bus.rd_data),
        .count_o (bus.fifo_count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (push && full && !bus.rd_en) begin
            overrun_q <= 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.bclkx8   = bclk_q;
    assign bus.rd_valid = ~empty;
    assign bus.overrun  = overrun_q;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_EDGES + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_q, rxs_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
            rxs_q     <= 1'b0;
        end else begin
            rxs_q <= bus.rx_status;
            if ((bus.rd_en && !empty) || (bus.rx_status && !rxs_q) || empty) begin
                tmo_cnt_q <= '0;
                tmo_q     <= 1'b0;
            end else if (state_q == IDLE && rise_q && !tmo_q) begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
                if (tmo_cnt_q + TW'(1) == TW'(TIMEOUT_EDGES)) tmo_q <= 1'b1;
            end
        end
    end

    assign bus.rx_timeout = tmo_q;
`else
    assign bus.rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: baud timing, frames, FIFO order, overrun, rx_en, reset.
module tb_uart_rx_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.DEPTH(8)) bus ();

    uart_rx_ctrl #(.FIFO_DEPTH(8)) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts bclkx8 rising edges, bounded by a cycle budget.
    task automatic rises(input int n);
        int   got = 0;
        int   c   = 0;
        logic prev;
        prev = bus.bclkx8;
        while (got < n && c < 2000) begin
            @(posedge clk);
            #1;
            if (bus.bclkx8 && !prev) got++;
            prev = bus.bclkx8;
            c++;
        end
        chk("rise_wait", 16'(got), 16'(n));
    endtask

    task automatic measure(output int hi, output int lo);
        hi = 1;
        lo = 1;
        forever begin
            cyc(1);
            if (bus.bclkx8 && hi < 100) hi++;
            else break;
        end
        forever begin
            cyc(1);
            if (!bus.bclkx8 && lo < 100) lo++;
            else break;
        end
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        cyc(1);
        bus.rd_en = 1'b0;
    endtask

    int hi, lo;

    initial begin
        rst_n         = 1'b0;
        bus.rx_en     = 1'b0;
        bus.cfg_div   = '0;
        bus.rx_status = 1'b0;
        bus.rhr       = '0;
        bus.rd_en     = 1'b0;
        bus.ovr_clr   = 1'b0;
        cyc(3);
        chk("rst_bclk", 16'(bus.bclkx8), 16'h0);
        chk("rst_data", 16'(bus.rd_data), 16'h0);
        chk("rst_valid", 16'(bus.rd_valid), 16'h0);
        chk("rst_count", 16'(bus.fifo_count), 16'h0);
        chk("rst_ovr", 16'(bus.overrun), 16'h0);
        chk("rst_tmo", 16'(bus.rx_timeout), 16'h0);

        rst_n       = 1'b1;
        bus.cfg_div = 16'd3;
        bus.rx_en   = 1'b1;
        rises(2);
        measure(hi, lo);
        chk("div3_hi", 16'(hi), 16'd3);
        chk("div3_lo", 16'(lo), 16'd3);

        bus.cfg_div = 16'd0;
        rises(3);
        measure(hi, lo);
        chk("div0_hi", 16'(hi), 16'd1);
        chk("div0_lo", 16'(lo), 16'd1);

        bus.cfg_div = 16'd1;
        rises(3);

        bus.rx_status = 1'b1;
        bus.rhr       = 8'hA5;
        rises(72);
        bus.rx_status = 1'b0;
        cyc(3);
        chk("a5_valid", 16'(bus.rd_valid), 16'h1);
        chk("a5_data", 16'(bus.rd_data), 16'hA5);
        chk("a5_count", 16'(bus.fifo_count), 16'd1);
        pop();
        chk("a5_pop_count", 16'(bus.fifo_count), 16'd0);
        chk("a5_pop_valid", 16'(bus.rd_valid), 16'h0);

        bus.rx_status = 1'b1;
        bus.rhr       = 8'h3C;
        rises(72);
        bus.rhr = 8'hC3;
        rises(72);
        bus.rx_status = 1'b0;
        cyc(3);
        chk("b2b_count", 16'(bus.fifo_count), 16'd2);
        chk("b2b_first", 16'(bus.rd_data), 16'h3C);
        pop();
        chk("b2b_second", 16'(bus.rd_data), 16'hC3);
        pop();
        chk("b2b_empty", 16'(bus.fifo_count), 16'd0);

        bus.rx_status = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.rhr = 8'(8'h10 + i);
            rises(72);
        end
        bus.rx_status = 1'b0;
        cyc(3);
        chk("ovr_count", 16'(bus.fifo_count), 16'd8);
        chk("ovr_flag", 16'(bus.overrun), 16'h1);
        chk("ovr_head", 16'(bus.rd_data), 16'h10);
        bus.ovr_clr = 1'b1;
        cyc(1);
        bus.ovr_clr = 1'b0;
        chk("ovr_clr", 16'(bus.overrun), 16'h0);
        chk("ovr_clr_count", 16'(bus.fifo_count), 16'd8);

        bus.rx_status = 1'b1;
        bus.rhr       = 8'h20;
        rises(70);
        cyc(1);
        bus.rd_en = 1'b1;
        cyc(1);
        bus.rd_en = 1'b0;
        rises(2);
        bus.rx_status = 1'b0;
        cyc(3);
        chk("pp_count", 16'(bus.fifo_count), 16'd8);
        chk("pp_ovr", 16'(bus.overrun), 16'h0);
        for (int i = 0; i < 8; i++) begin
            chk("drain", 16'(bus.rd_data), (i < 7) ? 16'(16'h11 + i) : 16'h20);
            pop();
        end
        chk("drain_count", 16'(bus.fifo_count), 16'd0);

        bus.rx_status = 1'b1;
        bus.rhr       = 8'h55;
        rises(30);
        bus.rx_en = 1'b0;
        cyc(2);
        chk("dis_bclk", 16'(bus.bclkx8), 16'h0);
        bus.rx_status = 1'b0;
        bus.rx_en     = 1'b1;
        cyc(200);
        chk("dis_count", 16'(bus.fifo_count), 16'd0);

        bus.rx_status = 1'b1;
        bus.rhr       = 8'h66;
        rises(72);
        bus.rhr = 8'h77;
        rises(40);
        chk("mid_count", 16'(bus.fifo_count), 16'd1);
        rst_n = 1'b0;
        #2;
        chk("mr_bclk", 16'(bus.bclkx8), 16'h0);
        chk("mr_data", 16'(bus.rd_data), 16'h0);
        chk("mr_valid", 16'(bus.rd_valid), 16'h0);
        chk("mr_count", 16'(bus.fifo_count), 16'h0);
        chk("mr_ovr", 16'(bus.overrun), 16'h0);
        chk("mr_tmo", 16'(bus.rx_timeout), 16'h0);
        bus.rx_status = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(200);
        chk("post_rst_count", 16'(bus.fifo_count), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
